// File: rtl/irq_pend8.sv
// Eight-channel request capture with a fixed-priority (bit 7 highest) one-hot
// grant offered through a valid/ready handshake.
module irq_pend8 #(
  parameter int EDGE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
  input  logic [7:0] mask,
  input  logic       grant_ready,
  input  logic       clr_ovf,
  output logic [7:0] grant,
  output logic       grant_valid,
  output logic [7:0] pending,
  output logic       overflow
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t     state_q;
  logic [7:0] req_q;
  logic [7:0] pending_q;
  logic [7:0] grant_q;
  logic       grant_valid_q;
  logic       overflow_q;

  logic [7:0] ev;
  logic [7:0] clr_vec;
  logic [7:0] pending_d;
  logic [7:0] lost_vec;
  logic [7:0] eligible;
  logic [7:0] pick;
  logic       overflow_d;

  // The handshake edge retires exactly the bit currently on offer.
  assign clr_vec  = (state_q == OFFER && grant_ready) ? grant_q : 8'h00;
  assign eligible = pending_q & mask;

  for (genvar gi = 0; gi < 8; gi++) begin : g_chan
    if (EDGE != 0) begin : g_edge
      assign ev[gi] = req_in[gi] & ~req_q[gi];
    end else begin : g_level
      assign ev[gi] = req_in[gi];
    end
    // A new event wins over the clear; a merged event is only "lost" if the
    // bit is still pending afterwards without being retired on this edge.
    assign pending_d[gi] = (pending_q[gi] & ~clr_vec[gi]) | ev[gi];
    assign lost_vec[gi]  = ev[gi] & pending_q[gi] & ~clr_vec[gi];
  end

  always_comb begin
    pick = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) pick = 8'h01 << i;
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (EDGE == 0) begin
      overflow_d = 1'b0;
    end else if (|lost_vec) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_q         <= 8'h00;
      pending_q     <= 8'h00;
      grant_q       <= 8'h00;
      grant_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      req_q      <= req_in;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      case (state_q)
        IDLE: begin
          if (|eligible) begin
            grant_q       <= pick;
            grant_valid_q <= 1'b1;
            state_q       <= OFFER;
          end
        end
        OFFER: begin
          if (grant_ready) begin
            grant_q       <= 8'h00;
            grant_valid_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          grant_q       <= 8'h00;
          grant_valid_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign pending     = pending_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_irq_pend8.sv
// Directed bench for irq_pend8: vector table for the basic flows, hand-written
// sequences for backpressure, collision, reset and level-capture behaviour.
module tb_irq_pend8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       grant_ready;
  logic       clr_ovf;
  logic [7:0] grant, grant_l;
  logic       grant_valid, grant_valid_l;
  logic [7:0] pending, pending_l;
  logic       overflow, overflow_l;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  irq_pend8 #(.EDGE(1)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask),
    .grant_ready(grant_ready), .clr_ovf(clr_ovf),
    .grant(grant), .grant_valid(grant_valid),
    .pending(pending), .overflow(overflow)
  );

  irq_pend8 #(.EDGE(0)) dut_lvl (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask),
    .grant_ready(grant_ready), .clr_ovf(clr_ovf),
    .grant(grant_l), .grant_valid(grant_valid_l),
    .pending(pending_l), .overflow(overflow_l)
  );

  typedef struct {
    logic [7:0] req;
    logic [7:0] msk;
    logic       rdy;
    logic       clr;
    logic       rs;
    logic [7:0] g;
    logic       v;
    logic [7:0] p;
    logic       o;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  // Apply inputs, take one rising edge, settle 1 time unit past it.
  task automatic step(input logic [7:0] r, input logic [7:0] m, input logic rdy,
                      input logic clr, input logic rs);
    req_in = r; mask = m; grant_ready = rdy; clr_ovf = clr; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] g, input logic v,
                         input logic [7:0] p, input logic o);
    $display("%s: req=%02h grant=%02h valid=%0b pending=%02h ovf=%0b",
             tag, req_in, grant, grant_valid, pending, overflow);
    chk({tag, ".grant"}, grant, g);
    chk({tag, ".valid"}, {7'd0, grant_valid}, {7'd0, v});
    chk({tag, ".pending"}, pending, p);
    chk({tag, ".ovf"}, {7'd0, overflow}, {7'd0, o});
  endtask

  initial begin
    req_in = 8'h00; mask = 8'hFF; grant_ready = 1'b0; clr_ovf = 1'b0; rst = 1'b1;

    //           req    mask  rdy   clr   rst   grant valid pend  ovf
    vecs[0]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    // single rising edge on bit 2
    vecs[1]  = '{8'h04, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 1'b0};
    vecs[2]  = '{8'h04, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h04, 1'b1, 8'h04, 1'b0};
    vecs[3]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    // priority: bits 7 and 0 together
    vecs[5]  = '{8'h81, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h81, 1'b0};
    vecs[6]  = '{8'h81, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 8'h81, 1'b0};
    vecs[7]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0};
    vecs[8]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 8'h01, 1'b0};
    vecs[9]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    // overflow: second edge on bit 3 while still pending, then clear
    vecs[11] = '{8'h08, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h08, 1'b0};
    vecs[12] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 8'h08, 1'b0};
    vecs[13] = '{8'h08, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 8'h08, 1'b1};
    vecs[14] = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h08, 1'b1, 8'h08, 1'b0};
    vecs[15] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].req, vecs[i].msk, vecs[i].rdy, vecs[i].clr, vecs[i].rs);
      chk_all($sformatf("vec%0d", i), vecs[i].g, vecs[i].v, vecs[i].p, vecs[i].o);
    end

    // Backpressure: grant on bit 5 held while masked off, then no new grant.
    step(8'h20, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk_all("bp.offer", 8'h20, 1'b1, 8'h20, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk_all($sformatf("bp.hold%0d", i), 8'h20, 1'b1, 8'h20, 1'b0);
    end
    step(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    chk_all("bp.accept", 8'h00, 1'b0, 8'h00, 1'b0);
    step(8'h10, 8'h00, 1'b1, 1'b0, 1'b0);
    chk_all("bp.masked_req", 8'h00, 1'b0, 8'h10, 1'b0);
    step(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    chk_all("bp.masked_idle", 8'h00, 1'b0, 8'h10, 1'b0);
    step(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk_all("bp.unmask", 8'h10, 1'b1, 8'h10, 1'b0);
    step(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    chk_all("bp.done", 8'h00, 1'b0, 8'h00, 1'b0);

    // Collision: fresh edge on bit 6 at the edge that retires bit 6.
    step(8'h40, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk_all("col.offer", 8'h40, 1'b1, 8'h40, 1'b0);
    step(8'h40, 8'hFF, 1'b1, 1'b0, 1'b0);
    chk_all("col.hs", 8'h00, 1'b0, 8'h40, 1'b0);
    step(8'h40, 8'hFF, 1'b1, 1'b0, 1'b0);
    chk_all("col.regrant", 8'h40, 1'b1, 8'h40, 1'b0);
    step(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    chk_all("col.done", 8'h00, 1'b0, 8'h00, 1'b0);

    // Reset mid-offer, request held high through release.
    step(8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk_all("rst.offer", 8'h01, 1'b1, 8'h01, 1'b0);
    step(8'h01, 8'hFF, 1'b1, 1'b0, 1'b1);
    chk_all("rst.assert", 8'h00, 1'b0, 8'h00, 1'b0);
    step(8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk_all("rst.rel1", 8'h00, 1'b0, 8'h01, 1'b0);
    step(8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk_all("rst.rel2", 8'h01, 1'b1, 8'h01, 1'b0);

    // Level capture instance: held request never flags overflow and re-pends.
    step(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
    step(8'h02, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("lvl.pend", pending_l, 8'h02);
    step(8'h02, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("lvl.grant", grant_l, 8'h02);
    step(8'h02, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("lvl.ovf", {7'd0, overflow_l}, 8'h00);
    chk("lvl.edge_pend", pending, 8'h02);
    step(8'h02, 8'hFF, 1'b1, 1'b0, 1'b0);
    chk("lvl.repend", pending_l, 8'h02);
    chk("lvl.valid", {7'd0, grant_valid_l}, 8'h00);
    chk("edge.cleared", pending, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
